hack_rom_loader: RTL and testbench
==================================

// Module: hack_rom_loader
// PURPOSE
//  Instruction-side partner of the Hack CPU. It owns the instruction ROM, answers the CPU's pc with instruction, and fills the
//  ROM from a byte stream. While a program loads it holds the CPU in reset, and releases it once the image is complete.
//  Sits between the host byte link (UART RX or testbench) and CPU.instruction / CPU.pc / CPU.reset.
// PARAMETERS
//  ADDR_W   15   ROM word-address width; depth = 2**ADDR_W 16-bit words
// PORTS
//  clk          in   1       system clock, rising edge
//  reset_n      in   1       asynchronous active-low reset
//  pc           in   16      CPU program counter
//  instruction  out  16      ROM word at pc (to CPU.instruction)
//  load_start   in   1       1-cycle pulse: begin a new image load
//  byte_data    in   8       stream byte
//  byte_valid   in   1       byte_data valid
//  byte_ready   out  1       loader can accept a byte this cycle
//  cpu_reset    out  1       active-high reset to the CPU (CPU.reset)
//  load_done    out  1       image loaded OK; CPU running
//  load_error   out  1       image rejected; CPU held in reset
//  word_count   out  ADDR_W+1  words written in the current or last load
// BEHAVIOUR
//  Reset (reset_n=0, async): state=IDLE, cpu_reset=1, byte_ready=0, load_done=0, load_error=0, word_count=0.
//   ROM contents are not cleared.
//  Byte transfer: a byte is consumed on a rising clk edge with byte_valid&byte_ready. byte_ready=1 only in the LEN_*/DATA_*/CHK_* states.
//  Image format, big-endian: LEN_HI, LEN_LO (N words), then N x {hi,lo}, then [CHK_HI, CHK_LO].
//  FSM: IDLE -load_start-> LEN_HI -> LEN_LO -> DATA_HI <-> DATA_LO -> (CHK_HI -> CHK_LO) -> DONE | ERROR.
//   LEN_LO accept: N=0 -> DONE (or CHK_HI if checksum enabled). N>2**ADDR_W -> ERROR. Otherwise -> DATA_HI.
//   DATA_LO accept: mem[wr_addr] <= {hi,byte}; wr_addr++, word_count++.
//    Goes to DATA_HI while word_count<N, else to the next stage.
//  cpu_reset=1 in every state except DONE. It falls on the clock edge that enters DONE.
//  load_done=1 only in DONE. load_error=1 only in ERROR.
//  load_start in any state (including mid-load, DONE or ERROR): next state LEN_HI, wr_addr=0, word_count=0,
//   cpu_reset=1, done/error cleared. A byte accepted in the same cycle is discarded (load_start wins).
//  Words beyond N keep their previous contents. wr_addr never wraps, because N is bounded by depth.
//  Read port: combinational. instruction = mem[pc[ADDR_W-1:0]] when pc < 2**ADDR_W and cpu_reset=0.
//   Otherwise instruction = 16'h0000. No added latency, so the CPU fetches in the same cycle.
//  Bytes presented in IDLE/DONE/ERROR are not accepted (byte_ready=0); the source holds them.
// CONFIGURATION
//  HACK_ROM_LOADER_CHECKSUM_EN defined:
//   - After the data, two bytes CHK_HI, CHK_LO carry the 16-bit wraparound sum of all N words (N=0 -> 16'h0000).
//   - Match -> DONE. Mismatch -> ERROR; the ROM keeps the written words and cpu_reset stays 1.
//  Undefined: no CHK states; the last DATA_LO accept (or N=0) goes straight to DONE.
// TESTING
//  1. reset_n=0 mid-stream -> next cycle cpu_reset=1, byte_ready=0, instruction=0, state IDLE.
//  2. Load N=2 as 00 02 30 39 EC 10 (plus checksum 1C 49 when enabled) ->
//     load_done=1, cpu_reset=0, word_count=2; pc=0 -> 16'h3039, pc=1 -> 16'hEC10.
//  3. Same image with byte_valid toggled every other cycle -> identical result; no byte lost or duplicated.
//  4. Header 80 01 with ADDR_W=15 (N=32769) -> load_error=1, cpu_reset=1, byte_ready=0, word_count=0.
//  5. load_start after the 1st data word of a 3-word load, then a fresh 1-word load of 00 01 AB CD (+ checksum AB CD) ->
//     word_count=1, mem[0]=16'hABCD, load_done=1.
//  6. CHECKSUM_EN: image 00 01 00 05 with checksum 00 06 -> load_error=1, cpu_reset=1, instruction=0 for every pc.

Source files
------------

// File: rtl/hack_rom_loader.sv
// hack_rom_loader
//   Instruction-side partner of the Hack CPU. Owns the instruction ROM,
//   serves CPU fetches combinationally, and fills the ROM from a big-endian
//   byte stream: LEN_HI, LEN_LO (N words), N x {hi, lo}, [CHK_HI, CHK_LO].
//   The CPU is held in reset while an image loads and released on success.
//
//   Optional feature macro: HACK_ROM_LOADER_CHECKSUM_EN
//     defined   -> image ends with a 16-bit wraparound sum of all N words;
//                  a mismatch ends in ERROR with the CPU held in reset.
//     undefined -> no checksum bytes; the last data word goes to DONE.
//
// Ports
//   clk          in   system clock, rising edge
//   reset_n      in   asynchronous active-low reset
//   pc           in   [15:0] CPU program counter
//   instruction  out  [15:0] ROM word at pc, 0 when out of range or CPU in reset
//   load_start   in   one-cycle pulse, restarts an image load from any state
//   byte_data    in   [7:0] stream byte
//   byte_valid   in   byte_data valid
//   byte_ready   out  loader accepts a byte this cycle
//   cpu_reset    out  active-high reset to the CPU, low only in DONE
//   load_done    out  image loaded, CPU running
//   load_error   out  image rejected, CPU held in reset
//   word_count   out  [ADDR_W:0] words written in the current or last load
module hack_rom_loader #(
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       pc,
  output logic [15:0]       instruction,
  input  logic              load_start,
  input  logic [7:0]        byte_data,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [ADDR_W:0]   word_count
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    S_CHK_HI,
    S_CHK_LO,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  // State entered once all data words are in (or N=0).
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  localparam state_t S_TAIL = S_CHK_HI;
`else
  localparam state_t S_TAIL = S_DONE;
`endif

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ADDR_W:0] r_word_count;
  logic [ADDR_W:0] w_word_count_nxt;
  logic [7:0]      r_hi;
  logic [15:0]     r_len;
  logic [15:0]     r_mem [DEPTH];
  logic            w_accept;
  logic            w_wr_en;
  logic [15:0]     w_word;
  logic [31:0]     w_count_inc;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  logic [15:0]     r_sum;
`endif

  // load_start wins over a byte handshake in the same cycle: the byte is dropped.
  assign w_accept    = byte_valid & byte_ready & ~load_start;
  // r_hi always holds the previously accepted byte, so every *_LO state
  // sees its full 16-bit field here.
  assign w_word      = {r_hi, byte_data};
  assign w_count_inc = 32'(r_word_count) + 32'd1;
  assign w_wr_en     = w_accept && (r_state == S_DATA_LO);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_word_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_word_count <= w_word_count_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt      = r_state;
    w_word_count_nxt = r_word_count;
    if (load_start) begin
      w_state_nxt      = S_LEN_HI;
      w_word_count_nxt = '0;
    end else if (w_accept) begin
      unique case (r_state)
        S_LEN_HI:  w_state_nxt = S_LEN_LO;
        S_LEN_LO: begin
          if (w_word == 16'h0000)
            w_state_nxt = S_TAIL;
          else if (32'(w_word) > DEPTH_U)
            w_state_nxt = S_ERROR;
          else
            w_state_nxt = S_DATA_HI;
        end
        S_DATA_HI: w_state_nxt = S_DATA_LO;
        S_DATA_LO: begin
          w_word_count_nxt = r_word_count + (ADDR_W+1)'(1);
          if (w_count_inc < 32'(r_len))
            w_state_nxt = S_DATA_HI;
          else
            w_state_nxt = S_TAIL;
        end
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
        S_CHK_HI:  w_state_nxt = S_CHK_LO;
        S_CHK_LO:  w_state_nxt = (w_word == r_sum) ? S_DONE : S_ERROR;
`endif
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  // Stream datapath: no reset, every register is rewritten before use in a load.
  always_ff @(posedge clk) begin
    if (w_accept)
      r_hi <= byte_data;
    if (w_accept && (r_state == S_LEN_LO))
      r_len <= w_word;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    if (load_start)
      r_sum <= '0;
    else if (w_wr_en)
      r_sum <= r_sum + w_word;
`endif
  end

  // ROM write port; N <= DEPTH keeps the address inside the array.
  always_ff @(posedge clk) begin
    if (w_wr_en)
      r_mem[r_word_count[ADDR_W-1:0]] <= w_word;
  end

  // Output logic
  always_comb begin
    byte_ready = (r_state == S_LEN_HI)  || (r_state == S_LEN_LO) ||
                 (r_state == S_DATA_HI) || (r_state == S_DATA_LO);
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    if ((r_state == S_CHK_HI) || (r_state == S_CHK_LO))
      byte_ready = 1'b1;
`endif
    cpu_reset   = (r_state != S_DONE);
    load_done   = (r_state == S_DONE);
    load_error  = (r_state == S_ERROR);
    word_count  = r_word_count;
    instruction = 16'h0000;
    if ((r_state == S_DONE) && (32'(pc) < DEPTH_U))
      instruction = r_mem[pc[ADDR_W-1:0]];
  end

endmodule

// File: tb/tb_hack_rom_loader.sv
// Testbench for hack_rom_loader: random and directed image loads checked
// against a word-level reference model of the ROM and the load outcome.
module tb_hack_rom_loader;
  localparam int ADDR_W = 15;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [15:0]       pc = 16'h0000;
  logic [15:0]       instruction;
  logic              load_start = 1'b0;
  logic [7:0]        byte_data = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              cpu_reset;
  logic              load_done;
  logic              load_error;
  logic [ADDR_W:0]   word_count;

  always #5 clk = ~clk;

  hack_rom_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .pc(pc), .instruction(instruction),
    .load_start(load_start), .byte_data(byte_data), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .cpu_reset(cpu_reset), .load_done(load_done),
    .load_error(load_error), .word_count(word_count)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: ROM image plus which words have ever been written.
  logic [15:0]     ref_mem   [DEPTH];
  bit              ref_known [DEPTH];
  logic [15:0]     img[$];
  logic            exp_done, exp_err;
  logic [ADDR_W:0] exp_wc;

  task automatic model_load(input int n, input bit bad_chk);
    if (n > DEPTH) begin
      exp_done = 1'b0; exp_err = 1'b1; exp_wc = '0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      ref_mem[i] = img[i];
      ref_known[i] = 1'b1;
    end
    exp_wc   = (ADDR_W+1)'(n);
    exp_err  = CHK_EN && bad_chk;
    exp_done = !exp_err;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    @(negedge clk);
    if (gap) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_data  = b;
    byte_valid = 1'b1;
    n = 0;
    while (!byte_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!byte_ready) begin
      errors++;
      $display("FAIL send_timeout: byte_ready=%b after %0d cycles, required 1", byte_ready, n);
    end
    @(posedge clk);
    #1 byte_valid = 1'b0;
  endtask

  task automatic pulse_start(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    load_start = 1'b1;
    if (with_byte) begin
      byte_data  = b;
      byte_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    load_start = 1'b0;
    byte_valid = 1'b0;
  endtask

  // Sends header, the first n words of img and, when enabled, the checksum.
  task automatic load_image(input int n, input bit gaps, input bit bad_chk,
                            input bit start_byte, input logic [7:0] sb);
    logic [15:0] sum;
    sum = 16'h0000;
    pulse_start(start_byte, sb);
    send_byte(8'(n >> 8), gaps);
    send_byte(8'(n), gaps);
    if (n > DEPTH) return;
    for (int i = 0; i < n; i++) begin
      send_byte(img[i][15:8], gaps);
      send_byte(img[i][7:0], gaps);
      sum = sum + img[i];
    end
    if (CHK_EN) begin
      sum = sum + {15'd0, bad_chk};
      send_byte(sum[15:8], gaps);
      send_byte(sum[7:0], gaps);
    end
  endtask

  task automatic set_pc(input logic [15:0] a);
    @(negedge clk);
    pc = a;
    #1;
  endtask

  task automatic test_reset;
    #1;
    checks++;
    if (cpu_reset !== 1'b1 || byte_ready !== 1'b0 || load_done !== 1'b0 ||
        load_error !== 1'b0 || word_count !== '0 || instruction !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: rst=%b rdy=%b done=%b err=%b wc=%0d instr=%h, required 1 0 0 0 0 0000",
               cpu_reset, byte_ready, load_done, load_error, word_count, instruction);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || cpu_reset !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_reset: rdy=%b rst=%b, required 0 1", byte_ready, cpu_reset);
    end
  endtask

  task automatic test_basic_load;
    img = '{16'h3039, 16'hEC10};
    load_image(2, 1'b0, 1'b0, 1'b0, 8'h00);
    model_load(2, 1'b0);
    @(negedge clk);
    checks++;
    if (load_done !== 1'b1 || load_error !== 1'b0 || cpu_reset !== 1'b0 ||
        word_count !== 16'd2 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_status: done=%b err=%b rst=%b wc=%0d rdy=%b, required 1 0 0 2 0",
               load_done, load_error, cpu_reset, word_count, byte_ready);
    end
    set_pc(16'd0);
    checks++;
    if (instruction !== 16'h3039) begin
      errors++;
      $display("FAIL basic_pc0: instr=%h required 3039", instruction);
    end
    set_pc(16'd1);
    checks++;
    if (instruction !== 16'hEC10) begin
      errors++;
      $display("FAIL basic_pc1: instr=%h required ec10", instruction);
    end
    set_pc(16'h8000);
    checks++;
    if (instruction !== 16'h0000) begin
      errors++;
      $display("FAIL pc_out_of_range: instr=%h required 0000", instruction);
    end
  endtask

  task automatic test_toggle_valid;
    img = '{16'hFFFF, 16'h0000};
    load_image(2, 1'b0, 1'b0, 1'b0, 8'h00);
    model_load(2, 1'b0);
    img = '{16'h3039, 16'hEC10};
    load_image(2, 1'b1, 1'b0, 1'b0, 8'h00);
    model_load(2, 1'b0);
    @(negedge clk);
    checks++;
    if (load_done !== exp_done || cpu_reset !== !exp_done || word_count !== exp_wc) begin
      errors++;
      $display("FAIL toggle_status: done=%b rst=%b wc=%0d, required %b %b %0d",
               load_done, cpu_reset, word_count, exp_done, !exp_done, exp_wc);
    end
    for (int i = 0; i < 2; i++) begin
      set_pc(16'(i));
      checks++;
      if (instruction !== ref_mem[i]) begin
        errors++;
        $display("FAIL toggle_pc%0d: instr=%h required %h", i, instruction, ref_mem[i]);
      end
    end
  endtask

  task automatic test_len_overflow;
    img.delete();
    load_image(DEPTH + 1, 1'b0, 1'b0, 1'b0, 8'h00);
    model_load(DEPTH + 1, 1'b0);
    @(negedge clk);
    checks++;
    if (load_error !== exp_err || load_done !== exp_done || cpu_reset !== 1'b1 ||
        byte_ready !== 1'b0 || word_count !== exp_wc) begin
      errors++;
      $display("FAIL len_overflow: err=%b done=%b rst=%b rdy=%b wc=%0d, required %b %b 1 0 %0d",
               load_error, load_done, cpu_reset, byte_ready, word_count, exp_err, exp_done, exp_wc);
    end
    set_pc(16'd0);
    checks++;
    if (instruction !== 16'h0000) begin
      errors++;
      $display("FAIL len_overflow_instr: instr=%h required 0000", instruction);
    end
  endtask

  task automatic test_restart;
    // Partial 3-word load: one word lands in mem[0] before the restart.
    pulse_start(1'b0, 8'h00);
    send_byte(8'h00, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h11, 1'b0);
    ref_mem[0] = 16'h1111;
    ref_known[0] = 1'b1;
    // The restart pulse carries a byte that must be dropped.
    img = '{16'hABCD};
    load_image(1, 1'b0, 1'b0, 1'b1, 8'h22);
    model_load(1, 1'b0);
    @(negedge clk);
    checks++;
    if (load_done !== 1'b1 || word_count !== 16'd1 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL restart_status: done=%b wc=%0d rst=%b, required 1 1 0",
               load_done, word_count, cpu_reset);
    end
    set_pc(16'd0);
    checks++;
    if (instruction !== 16'hABCD) begin
      errors++;
      $display("FAIL restart_pc0: instr=%h required abcd", instruction);
    end
    set_pc(16'd1);
    checks++;
    if (instruction !== ref_mem[1]) begin
      errors++;
      $display("FAIL restart_keep_pc1: instr=%h required %h", instruction, ref_mem[1]);
    end
  endtask

  task automatic test_zero_len;
    img.delete();
    load_image(0, 1'b0, 1'b0, 1'b0, 8'h00);
    model_load(0, 1'b0);
    @(negedge clk);
    checks++;
    if (load_done !== 1'b1 || word_count !== '0 || cpu_reset !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_status: done=%b wc=%0d rst=%b, required 1 0 0",
               load_done, word_count, cpu_reset);
    end
    for (int i = 0; i < 2; i++) begin
      set_pc(16'(i));
      checks++;
      if (instruction !== ref_mem[i]) begin
        errors++;
        $display("FAIL zero_len_keep_pc%0d: instr=%h required %h", i, instruction, ref_mem[i]);
      end
    end
  endtask

  task automatic test_random_loads;
    int n;
    bit g;
    for (int t = 0; t < 6; t++) begin
      n = int'($urandom_range(1, 24));
      g = 1'($urandom_range(0, 1));
      img.delete();
      for (int i = 0; i < n; i++) img.push_back(16'($urandom));
      load_image(n, g, 1'b0, 1'b0, 8'h00);
      model_load(n, 1'b0);
      @(negedge clk);
      checks++;
      if (load_done !== exp_done || load_error !== exp_err || word_count !== exp_wc) begin
        errors++;
        $display("FAIL random%0d_status: done=%b err=%b wc=%0d, required %b %b %0d",
                 t, load_done, load_error, word_count, exp_done, exp_err, exp_wc);
      end
      for (int i = 0; i < n + 4; i++) begin
        if (ref_known[i]) begin
          set_pc(16'(i));
          checks++;
          if (instruction !== ref_mem[i]) begin
            errors++;
            $display("FAIL random%0d_pc%0d: instr=%h required %h", t, i, instruction, ref_mem[i]);
          end
        end
      end
    end
  endtask

`ifdef HACK_ROM_LOADER_CHECKSUM_EN
  task automatic test_checksum;
    img = '{16'h0005};
    load_image(1, 1'b0, 1'b1, 1'b0, 8'h00);
    model_load(1, 1'b1);
    @(negedge clk);
    checks++;
    if (load_error !== 1'b1 || load_done !== 1'b0 || cpu_reset !== 1'b1 || word_count !== 16'd1) begin
      errors++;
      $display("FAIL chk_bad_status: err=%b done=%b rst=%b wc=%0d, required 1 0 1 1",
               load_error, load_done, cpu_reset, word_count);
    end
    for (int i = 0; i < 4; i++) begin
      set_pc(16'($urandom_range(0, 65535)) & ((i == 0) ? 16'h0000 : 16'hFFFF));
      checks++;
      if (instruction !== 16'h0000) begin
        errors++;
        $display("FAIL chk_bad_instr pc=%h: instr=%h required 0000", pc, instruction);
      end
    end
    // The rejected word stays in the ROM and shows after an empty load.
    img.delete();
    load_image(0, 1'b0, 1'b0, 1'b0, 8'h00);
    model_load(0, 1'b0);
    set_pc(16'd0);
    checks++;
    if (load_done !== 1'b1 || instruction !== ref_mem[0]) begin
      errors++;
      $display("FAIL chk_rom_kept: done=%b instr=%h, required 1 %h", load_done, instruction, ref_mem[0]);
    end
  endtask
`endif

  task automatic test_reset_midstream;
    pulse_start(1'b0, 8'h00);
    send_byte(8'h00, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h12, 1'b0);
    @(negedge clk);
    pc = 16'd0;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (cpu_reset !== 1'b1 || byte_ready !== 1'b0 || instruction !== 16'h0000 || word_count !== '0) begin
      errors++;
      $display("FAIL midreset_async: rst=%b rdy=%b instr=%h wc=%0d, required 1 0 0000 0",
               cpu_reset, byte_ready, instruction, word_count);
    end
    @(negedge clk);
    reset_n = 1'b1;
    byte_data = 8'h55;
    byte_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || load_done !== 1'b0 || load_error !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: rdy=%b done=%b err=%b, required 0 0 0",
               byte_ready, load_done, load_error);
    end
    byte_valid = 1'b0;
    img.delete();
    load_image(0, 1'b0, 1'b0, 1'b0, 8'h00);
    model_load(0, 1'b0);
    set_pc(16'd0);
    checks++;
    if (load_done !== 1'b1 || instruction !== ref_mem[0]) begin
      errors++;
      $display("FAIL midreset_rom_kept: done=%b instr=%h, required 1 %h", load_done, instruction, ref_mem[0]);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_load();
    test_toggle_valid();
    test_len_overflow();
    test_restart();
    test_zero_len();
    test_random_loads();
`ifdef HACK_ROM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
